// File: rtl/cla_seq_add_ctrl.sv
// Nibble-serial adder: one 4-bit carry-lookahead slice reused NIB times, LSB nibble first.
// Optional two's-complement overflow output enabled by defining CLA_SEQ_OVF_FLAG_EN.
module cla_seq_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef CLA_SEQ_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic [IDXW-1:0]   idx_q, idx_d;
`ifdef CLA_SEQ_OVF_FLAG_EN
    logic              ovf_q, ovf_d;
`endif

    logic [3:0] a_nib, b_nib, p, g, nib_sum;
    logic       c1, c2, c3, grp_p, grp_g, nib_co;
    logic       last_nib;

    // Lookahead slice on the currently selected nibble of the latched operands.
    always_comb begin
        a_nib   = a_q[{idx_q, 2'b00} +: 4];
        b_nib   = b_q[{idx_q, 2'b00} +: 4];
        p       = a_nib ^ b_nib;
        g       = a_nib & b_nib;
        c1      = g[0] | (p[0] & carry_q);
        c2      = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
        c3      = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry_q);
        grp_p   = &p;
        grp_g   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        nib_co  = grp_g | (grp_p & carry_q);
        nib_sum = p ^ {c3, c2, c1, carry_q};
    end

    assign last_nib = (idx_q == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (last_nib) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
`ifdef CLA_SEQ_OVF_FLAG_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = ci;
                    idx_d   = '0;
                    sum_d   = '0;
                end
            end
            RUN: begin
                sum_d[{idx_q, 2'b00} +: 4] = nib_sum;
                carry_d = nib_co;
                if (last_nib) begin
                    // Index parks at zero rather than wrapping past the last nibble.
                    idx_d  = '0;
                    cout_d = nib_co;
`ifdef CLA_SEQ_OVF_FLAG_EN
                    ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_sum[3] != a_q[WIDTH-1]);
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
`ifdef CLA_SEQ_OVF_FLAG_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
`ifdef CLA_SEQ_OVF_FLAG_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef CLA_SEQ_OVF_FLAG_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_cla_seq_add_ctrl.sv
// Bench for cla_seq_add_ctrl: 16-bit instance checked every cycle against a transaction model,
// plus directed literal checks and a 4-bit instance.
module tb_cla_seq_add_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0, out_ready = 1'b0, ci = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        in_ready, out_valid, cout, busy;
    logic [15:0] sum;

    logic        in_valid4 = 1'b0, out_ready4 = 1'b0, ci4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        in_ready4, out_valid4, cout4, busy4;
    logic [3:0]  sum4;
`ifdef CLA_SEQ_OVF_FLAG_EN
    logic        ovf, ovf4;
`endif

    int checks = 0;
    int errors = 0;

    cla_seq_add_ctrl #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
`ifdef CLA_SEQ_OVF_FLAG_EN
        , .ovf(ovf)
`endif
    );

    cla_seq_add_ctrl #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .ci(ci4), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .busy(busy4)
`ifdef CLA_SEQ_OVF_FLAG_EN
        , .ovf(ovf4)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: 0 = waiting for operands, 1 = computing, 2 = result offered.
    int          mode = 0;
    int          rem = 0;
    logic [15:0] exp_sum = '0;
    logic        exp_cout = 1'b0;
    logic        exp_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        logic [16:0] full;
        if (!rst_n) begin
            mode = 0; exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
        end else begin
            case (mode)
                0: if (in_valid) begin
                    full     = {1'b0, a} + {1'b0, b} + {16'b0, ci};
                    exp_sum  = full[15:0];
                    exp_cout = full[16];
                    exp_ovf  = (a[15] == b[15]) && (full[15] != a[15]);
                    rem      = 4;
                    mode     = 1;
                end
                1: begin
                    rem--;
                    if (rem == 0) mode = 2;
                end
                default: if (out_ready) mode = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("out_valid", {31'b0, out_valid}, {31'b0, mode == 2});
        chk("in_ready", {31'b0, in_ready}, {31'b0, mode == 0});
        chk("busy", {31'b0, busy}, {31'b0, mode != 0});
        if (mode != 1) begin
            chk("sum", {16'b0, sum}, {16'b0, exp_sum});
            chk("cout", {31'b0, cout}, {31'b0, exp_cout});
`ifdef CLA_SEQ_OVF_FLAG_EN
            chk("ovf", {31'b0, ovf}, {31'b0, exp_ovf});
`endif
        end
    end

    task automatic accept16(input logic [15:0] av, input logic [15:0] bv, input logic civ);
        int n;
        n = 0;
        @(posedge clk); #2;
        while (!in_ready && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        chk("accept_ready", {31'b0, in_ready}, 32'd1);
        a = av; b = bv; ci = civ; in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #2;
            lat++;
        end
    endtask

    task automatic run16(input logic [15:0] av, input logic [15:0] bv, input logic civ,
                         input logic [15:0] es, input logic ec, input logic eo);
        int lat;
        out_ready = 1'b1;
        accept16(av, bv, civ);
        wait_valid(lat);
        chk("latency", lat, 32'd4);
        chk("sum_lit", {16'b0, sum}, {16'b0, es});
        chk("cout_lit", {31'b0, cout}, {31'b0, ec});
`ifdef CLA_SEQ_OVF_FLAG_EN
        chk("ovf_lit", {31'b0, ovf}, {31'b0, eo});
`else
        if (eo === 1'bx) chk("ovf_arg", 32'd0, 32'd1);
`endif
        @(posedge clk); #2;
        chk("in_ready_after", {31'b0, in_ready}, 32'd1);
        $display("op %h + %h + %0d -> sum %h cout %0d latency %0d", av, bv, civ, es, ec, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        #22 rst_n = 1'b1;
        chk("reset_in_ready4", {31'b0, in_ready4}, 32'd1);
        chk("reset_sum", {16'b0, sum}, 32'd0);

        // 4-bit instance: single-cycle iteration.
        a4 = 4'h9; b4 = 4'h8; ci4 = 1'b0;
        @(posedge clk); #2; in_valid4 = 1'b1;
        @(posedge clk); #2; in_valid4 = 1'b0;
        chk("w4_valid_early", {31'b0, out_valid4}, 32'd0);
        @(posedge clk); #2;
        chk("w4_valid", {31'b0, out_valid4}, 32'd1);
        chk("w4_sum", {28'b0, sum4}, 32'h1);
        chk("w4_cout", {31'b0, cout4}, 32'd1);
`ifdef CLA_SEQ_OVF_FLAG_EN
        chk("w4_ovf", {31'b0, ovf4}, 32'd1);
`endif
        out_ready4 = 1'b1;
        @(posedge clk); #2;
        chk("w4_in_ready", {31'b0, in_ready4}, 32'd1);
        $display("op4 9 + 8 + 0 -> sum %h cout %0d", sum4, cout4);

        run16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run16(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
        run16(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        run16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);

        // Backpressure with an ignored operand pulse during the stall.
        out_ready = 1'b0;
        accept16(16'hA5A5, 16'h0000, 1'b0);
        wait_valid(lat);
        chk("bp_latency", lat, 32'd4);
        for (int i = 0; i < 5; i++) begin
            chk("bp_sum", {16'b0, sum}, 32'hA5A5);
            chk("bp_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            if (i == 1) begin
                a = 16'h1234; b = 16'h1111; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;
        chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
        chk("bp_release_sum", {16'b0, sum}, 32'hA5A5);
        chk("bp_release_valid", {31'b0, out_valid}, 32'd0);
        $display("op a5a5 + 0000 + 0 stalled 5 cycles -> sum %h", sum);

        // Reset two RUN cycles into an operation.
        accept16(16'h0F0F, 16'h0101, 1'b0);
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_sum", {16'b0, sum}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        $display("op 0f0f + 0101 aborted by reset -> sum %h", sum);
        @(posedge clk); #2;
        rst_n = 1'b1;
        run16(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        @(posedge clk); #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
